// File: rtl/fpga_demo_loader.sv
// Host-side driver for the tiny processor demo: holds it in reset, shifts in a built-in
// program over a mode-tagged serial link, waits for done, then runs and steps the display.
module fpga_demo_loader #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned WORD_W     = 8,
  parameter int unsigned PROG_WORDS = 16,
  parameter int unsigned RST_CYC    = 4,
  parameter int unsigned DISP_HOLD  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drive,
  input  logic       done_in,
  output logic       sclk_out,
  output logic       rst_n_out,
  output logic       mosi_out,
  output logic [1:0] mode_out,
  output logic       display_on,
  output logic       lsB,
  output logic [3:0] addr_in
);

  localparam int unsigned TOTAL_BITS = PROG_WORDS * WORD_W;
  localparam int unsigned CNT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RST_W      = $clog2(RST_CYC + 1);
  localparam int unsigned DISP_W     = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_LOAD,
    S_WAIT_DONE,
    S_RUN
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [RST_W-1:0]   rst_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DISP_W-1:0]  disp_cnt;
  logic               done_meta;
  logic               done_sync;
  logic               sclk_fall_c;

  // Built-in demo program; words beyond the table read as zero.
  function automatic logic [WORD_W-1:0] rom_word(input int unsigned idx);
    logic [7:0] b;
    case (idx)
      0:       b = 8'h3C;
      1:       b = 8'hA5;
      2:       b = 8'h01;
      3:       b = 8'hF0;
      4:       b = 8'h7E;
      5:       b = 8'h81;
      6:       b = 8'h5A;
      7:       b = 8'hC3;
      8:       b = 8'h12;
      9:       b = 8'h34;
      10:      b = 8'h56;
      11:      b = 8'h78;
      12:      b = 8'h9A;
      13:      b = 8'hBC;
      14:      b = 8'hDE;
      15:      b = 8'hFF;
      default: b = 8'h00;
    endcase
    return WORD_W'(b);
  endfunction

  // Word-major, MSB-first bit of the serial program stream.
  function automatic logic stream_bit(input logic [CNT_W-1:0] idx);
    int unsigned       pos;
    logic [WORD_W-1:0] w;
    pos = 32'(idx);
    w   = rom_word(pos / WORD_W) >> (WORD_W - 1 - (pos % WORD_W));
    return w[0];
  endfunction

  assign sclk_fall_c = sclk_out && (div_cnt == DIV_W'(CLK_DIV - 1));

  // done_in comes from the sclk domain; two-flop synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
    end else begin
      done_meta <= done_in;
      done_sync <= done_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      rst_cnt    <= '0;
      bit_cnt    <= '0;
      disp_cnt   <= '0;
      sclk_out   <= 1'b0;
      rst_n_out  <= 1'b0;
      mosi_out   <= 1'b0;
      mode_out   <= MODE_IDLE;
      display_on <= 1'b0;
      lsB        <= 1'b0;
      addr_in    <= 4'd0;
    end else if (state != S_IDLE && !drive) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      rst_cnt    <= '0;
      bit_cnt    <= '0;
      disp_cnt   <= '0;
      sclk_out   <= 1'b0;
      rst_n_out  <= 1'b0;
      mosi_out   <= 1'b0;
      mode_out   <= MODE_IDLE;
      display_on <= 1'b0;
      lsB        <= 1'b0;
      addr_in    <= 4'd0;
    end else begin
      // Processor clock runs in every state except IDLE.
      if (state == S_IDLE) begin
        div_cnt  <= '0;
        sclk_out <= 1'b0;
      end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
        div_cnt  <= '0;
        sclk_out <= ~sclk_out;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (drive) state <= S_RST_HOLD;
        end
        S_RST_HOLD: begin
          if (sclk_fall_c) begin
            if (rst_cnt == RST_W'(RST_CYC - 1)) begin
              rst_n_out <= 1'b1;
              mode_out  <= MODE_LOAD;
              bit_cnt   <= '0;
              mosi_out  <= stream_bit('0);
              state     <= S_LOAD;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (sclk_fall_c) begin
            if (bit_cnt == CNT_W'(TOTAL_BITS - 1)) begin
              mosi_out <= 1'b0;
              state    <= S_WAIT_DONE;
            end else begin
              bit_cnt  <= bit_cnt + 1'b1;
              mosi_out <= stream_bit(bit_cnt + 1'b1);
            end
          end
        end
        S_WAIT_DONE: begin
          if (sclk_fall_c && done_sync) begin
            mode_out   <= MODE_RUN;
            display_on <= 1'b1;
            disp_cnt   <= '0;
            lsB        <= 1'b0;
            addr_in    <= 4'd0;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          // lsB toggles every DISP_HOLD clocks; address advances when lsB wraps.
          if (disp_cnt == DISP_W'(DISP_HOLD - 1)) begin
            disp_cnt <= '0;
            lsB      <= ~lsB;
            if (lsB) addr_in <= addr_in + 4'd1;
          end else begin
            disp_cnt <= disp_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_demo_loader.sv
// Self-checking bench for fpga_demo_loader: reset, reset-hold timing, serial load
// bitstream, done handshake, run-mode display stepping and aborts.
`timescale 1ns/1ps
module tb_fpga_demo_loader;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned WORD_W     = 8;
  localparam int unsigned PROG_WORDS = 16;
  localparam int unsigned RST_CYC    = 4;
  localparam int unsigned DISP_HOLD  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       drive = 1'b0;
  logic       done_in = 1'b0;
  logic       sclk_out, rst_n_out, mosi_out, display_on, lsB;
  logic [1:0] mode_out;
  logic [3:0] addr_in;

  int checks = 0;
  int failures = 0;

  logic [7:0] rom [16] = '{8'h3C, 8'hA5, 8'h01, 8'hF0, 8'h7E, 8'h81, 8'h5A, 8'hC3,
                           8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hFF};
  bit exp_q[$];

  fpga_demo_loader #(
    .CLK_DIV(CLK_DIV), .WORD_W(WORD_W), .PROG_WORDS(PROG_WORDS),
    .RST_CYC(RST_CYC), .DISP_HOLD(DISP_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .drive(drive), .done_in(done_in),
    .sclk_out(sclk_out), .rst_n_out(rst_n_out), .mosi_out(mosi_out),
    .mode_out(mode_out), .display_on(display_on), .lsB(lsB), .addr_in(addr_in)
  );

  always #5 clk = ~clk;

  // Counts processor-facing output changes that do not coincide with an sclk fall.
  bit         mon_en = 1'b0;
  int         edge_viol = 0;
  logic [3:0] mon_prev = '0;
  logic       mon_sclk = 1'b0;
  always @(negedge clk) begin
    if (mon_en && ({mosi_out, mode_out, rst_n_out} !== mon_prev) && !(mon_sclk === 1'b1 && sclk_out === 1'b0))
      edge_viol = edge_viol + 1;
    mon_prev = {mosi_out, mode_out, rst_n_out};
    mon_sclk = sclk_out;
  end

  function automatic logic [10:0] all_outs();
    return {sclk_out, rst_n_out, mosi_out, mode_out, display_on, lsB, addr_in};
  endfunction

  task automatic fill_queue(input int nbits);
    exp_q.delete();
    for (int i = 0; i < nbits; i++) begin
      logic [7:0] w;
      w = rom[i / 8];
      exp_q.push_back(w[7 - (i % 8)]);
    end
  endtask

  task automatic wait_rise(output bit ok);
    logic p;
    ok = 1'b0;
    p = sclk_out;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (p === 1'b0 && sclk_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      p = sclk_out;
    end
  endtask

  task automatic wait_fall(output bit ok);
    logic p;
    ok = 1'b0;
    p = sclk_out;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (p === 1'b1 && sclk_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
      p = sclk_out;
    end
  endtask

  task automatic wait_load_start(output int cyc);
    cyc = 0;
    while (rst_n_out !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_async: got %0h expected 0", all_outs());
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (all_outs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_idle: got %0h expected 0", all_outs());
    end
  endtask

  task automatic test_rst_hold;
    int cyc;
    int rises;
    logic p;
    fill_queue(PROG_WORDS * WORD_W);
    mon_en = 1'b1;
    drive = 1'b1;
    cyc = 0;
    rises = 0;
    p = sclk_out;
    while (rst_n_out !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (p === 1'b0 && sclk_out === 1'b1) rises++;
      p = sclk_out;
    end
    checks++;
    if (cyc != 1 + RST_CYC * 2 * CLK_DIV) begin
      failures++;
      $display("FAIL rst_hold_cycles: got %0d expected %0d", cyc, 1 + RST_CYC * 2 * CLK_DIV);
    end
    checks++;
    if (rises != RST_CYC) begin
      failures++;
      $display("FAIL rst_hold_periods: got %0d expected %0d", rises, RST_CYC);
    end
    checks++;
    if ({sclk_out, mode_out, mosi_out} !== {1'b0, 2'b01, rom[0][7]}) begin
      failures++;
      $display("FAIL load_entry: got %0b expected %0b", {sclk_out, mode_out, mosi_out}, {1'b0, 2'b01, rom[0][7]});
    end
  endtask

  task automatic test_load;
    bit ok;
    bit exp;
    int idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      wait_rise(ok);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL load_timeout: got no sclk rise at bit %0d expected a rise", idx);
        break;
      end
      exp = exp_q.pop_front();
      checks++;
      if (mosi_out !== exp || mode_out !== 2'b01 || rst_n_out !== 1'b1) begin
        failures++;
        $display("FAIL load_bit%0d: got mosi=%0b mode=%0b expected mosi=%0b mode=01", idx, mosi_out, mode_out, exp);
      end
      idx++;
    end
    wait_rise(ok);
    checks++;
    if (!ok || mosi_out !== 1'b0 || mode_out !== 2'b01) begin
      failures++;
      $display("FAIL load_end: got ok=%0b mosi=%0b mode=%0b expected ok=1 mosi=0 mode=01", ok, mosi_out, mode_out);
    end
  endtask

  task automatic test_wait_done;
    bit ok;
    int cyc;
    repeat (40) @(negedge clk);
    checks++;
    if ({mode_out, mosi_out, display_on} !== 4'b0100) begin
      failures++;
      $display("FAIL wait_hold: got %0b expected 0100", {mode_out, mosi_out, display_on});
    end
    wait_fall(ok);
    done_in = 1'b1;
    cyc = 0;
    while (mode_out !== 2'b11 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc > 3 + CLK_DIV) begin
      failures++;
      $display("FAIL done_latency: got %0d expected <= %0d", cyc, 3 + CLK_DIV);
    end
    checks++;
    if ({display_on, lsB, addr_in} !== 6'b100000) begin
      failures++;
      $display("FAIL run_entry: got %0b expected 100000", {display_on, lsB, addr_in});
    end
    checks++;
    if (edge_viol != 0) begin
      failures++;
      $display("FAIL sclk_fall_only: got %0d off-edge changes expected 0", edge_viol);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_run;
    int cnt;
    logic m_lsb;
    logic [3:0] m_addr;
    int bad;
    cnt = 0;
    m_lsb = 1'b0;
    m_addr = 4'd0;
    bad = 0;
    for (int i = 0; i < 34 * DISP_HOLD; i++) begin
      @(negedge clk);
      cnt++;
      if (cnt == DISP_HOLD) begin
        cnt = 0;
        if (m_lsb) m_addr = m_addr + 4'd1;
        m_lsb = ~m_lsb;
      end
      checks++;
      if ({lsB, addr_in} !== {m_lsb, m_addr}) begin
        failures++;
        $display("FAIL run_disp_c%0d: got lsB=%0b addr=%0d expected lsB=%0b addr=%0d", i, lsB, addr_in, m_lsb, m_addr);
      end
    end
    checks++;
    if ({mode_out, display_on} !== 3'b111) begin
      failures++;
      $display("FAIL run_mode: got %0b expected 111", {mode_out, display_on});
    end
    done_in = 1'b0;
    drive = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs() !== 11'd0) begin
      failures++;
      $display("FAIL run_drop: got %0h expected 0", all_outs());
    end
  endtask

  task automatic test_abort_load;
    bit ok;
    bit exp;
    int cyc;
    done_in = 1'b1;
    drive = 1'b1;
    wait_load_start(cyc);
    fill_queue(20);
    while (exp_q.size() > 0) begin
      wait_rise(ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || mosi_out !== exp || mode_out !== 2'b01) begin
        failures++;
        $display("FAIL reload_bit: got ok=%0b mosi=%0b mode=%0b expected ok=1 mosi=%0b mode=01", ok, mosi_out, mode_out, exp);
      end
    end
    drive = 1'b0;
    @(negedge clk);
    checks++;
    if (all_outs() !== 11'd0) begin
      failures++;
      $display("FAIL abort_idle: got %0h expected 0", all_outs());
    end
    drive = 1'b1;
    wait_load_start(cyc);
    checks++;
    if (cyc != 1 + RST_CYC * 2 * CLK_DIV) begin
      failures++;
      $display("FAIL abort_rehold: got %0d expected %0d", cyc, 1 + RST_CYC * 2 * CLK_DIV);
    end
    fill_queue(WORD_W);
    while (exp_q.size() > 0) begin
      wait_rise(ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || mosi_out !== exp) begin
        failures++;
        $display("FAIL restart_word0: got ok=%0b mosi=%0b expected ok=1 mosi=%0b", ok, mosi_out, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_midload: got %0h expected 0", all_outs());
    end
    drive = 1'b0;
    done_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 11'd0) begin
      failures++;
      $display("FAIL reset_release: got %0h expected 0", all_outs());
    end
  endtask

  initial begin
    test_reset();
    test_rst_hold();
    test_load();
    test_wait_done();
    test_run();
    test_abort_load();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
